sigmoid_arbiter: RTL and testbench

//   Shares one sigmoid unit (piecewise-linear, Q8.8 in, 8-bit out) among
//   NUM_REQ requesters, e.g. the hidden- or visible-unit sum accumulators of
//   an RBM layer. Round-robin arbitration, valid/ready handshake on both

---
 rtl/sigmoid_arbiter.sv | 129 ++++++++++++
 tb/tb_sigmoid_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one piecewise-linear sigmoid unit (Q8.8 in, 8-bit out)
// among NUM_REQ accumulators; one registered, requester-tagged result per cycle.

module sigmoid_pwl #(
  parameter int INPUT_BITLENGTH   = 16,
  parameter int SIGMOID_BITLENGTH = 8
) (
  input  logic [INPUT_BITLENGTH-1:0]   sum_i,
  output logic [SIGMOID_BITLENGTH-1:0] s_o
);
  // One extra bit so |0x8000| does not wrap; at least 14 bits for the [13:5] slice.
  localparam int AW = (INPUT_BITLENGTH + 1 > 14) ? INPUT_BITLENGTH + 1 : 14;

  logic [AW-1:0] x, a;
  logic [9:0]    v, r;
  logic [7:0]    s8;

  always_comb begin
    x = {{(AW-INPUT_BITLENGTH){sum_i[INPUT_BITLENGTH-1]}}, sum_i};
    a = x[AW-1] ? (~x + 1'b1) : x;
    if (a > AW'('h500))      v = 10'd256;
    else if (a > AW'('h260)) v = 10'(a[13:5]) + 10'd216;
    else if (a > AW'('h100)) v = 10'(a[11:3]) + 10'd160;
    else                     v = 10'(a[10:2]) + 10'd128;
    r  = x[AW-1] ? (10'd256 - v) : v;
    s8 = (r > 10'd255) ? 8'hFF : r[7:0];
    s_o = SIGMOID_BITLENGTH'(s8);
  end
endmodule

module sigmoid_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int INPUT_BITLENGTH   = 16,
  parameter int SIGMOID_BITLENGTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ*INPUT_BITLENGTH-1:0]   req_sum_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic                                 out_valid_o,
  output logic [$clog2(NUM_REQ)-1:0]           out_id_o,
  output logic [SIGMOID_BITLENGTH-1:0]         out_s_o,
  input  logic                                 out_ready_i
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e                                   state_q, state_d;
  logic [ID_W-1:0]                          out_id_q, out_id_d;
  logic [ID_W-1:0]                          rr_ptr_q, rr_ptr_d;
  logic [SIGMOID_BITLENGTH-1:0]             out_s_q, out_s_d;
  logic [NUM_REQ-1:0][INPUT_BITLENGTH-1:0]  sum_v;
  logic [ID_W-1:0]                          gnt_id;
  logic                                     found, load, grant;
  logic [SIGMOID_BITLENGTH-1:0]             sig;
  int                                       idx;

  assign sum_v = req_sum_i;

  // Cyclic search starting at rr_ptr; first hit wins.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  // rst_n gates the grant so req_ready stays low while reset is held.
  assign load        = (state_q == EMPTY) | out_ready_i;
  assign grant       = load & found & rst_n;
  assign req_ready_o = grant ? (NUM_REQ'(1) << gnt_id) : '0;

  sigmoid_pwl #(
    .INPUT_BITLENGTH  (INPUT_BITLENGTH),
    .SIGMOID_BITLENGTH(SIGMOID_BITLENGTH)
  ) u_sig (
    .sum_i(sum_v[gnt_id]),
    .s_o  (sig)
  );

  always_comb begin
    state_d  = state_q;
    out_id_d = out_id_q;
    out_s_d  = out_s_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      EMPTY, FULL: begin
        if (load) begin
          if (grant) begin
            state_d  = FULL;
            out_id_d = gnt_id;
            out_s_d  = sig;
            rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
          end else begin
            state_d  = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      out_id_q <= '0;
      out_s_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      out_id_q <= out_id_d;
      out_s_q  <= out_s_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_id_o    = out_id_q;
  assign out_s_o     = out_s_q;
endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter: a 4-requester instance and a 3-requester
// instance for the non-power-of-two wrap case.

module tb_sigmoid_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  valid4, ready4;
  logic [63:0] sum4;
  logic        ov4, ordy4;
  logic [1:0]  id4;
  logic [7:0]  s4;

  logic [2:0]  valid3, ready3;
  logic [47:0] sum3;
  logic        ov3, ordy3;
  logic [1:0]  id3;
  logic [7:0]  s3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sigmoid_arbiter #(.NUM_REQ(4), .INPUT_BITLENGTH(16), .SIGMOID_BITLENGTH(8)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid4), .req_sum_i(sum4),
    .req_ready_o(ready4), .out_valid_o(ov4), .out_id_o(id4), .out_s_o(s4),
    .out_ready_i(ordy4));

  sigmoid_arbiter #(.NUM_REQ(3), .INPUT_BITLENGTH(16), .SIGMOID_BITLENGTH(8)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid3), .req_sum_i(sum3),
    .req_ready_o(ready3), .out_valid_o(ov3), .out_id_o(id3), .out_s_o(s3),
    .out_ready_i(ordy3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vin  [16] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0600, 16'hFA00, 16'h8000,
                             16'h0200, 16'h0180, 16'h0260, 16'h0261, 16'h0400, 16'hFC00,
                             16'h0500, 16'hFB00, 16'hFFFF, 16'h7FFF};
  logic [7:0]  vexp [16] = '{8'd128, 8'd192, 8'd64, 8'd255, 8'd0, 8'd0,
                             8'd224, 8'd208, 8'd236, 8'd235, 8'd248, 8'd8,
                             8'd255, 8'd0, 8'd128, 8'd255};
  logic [7:0]  fexp [4]  = '{8'd128, 8'd192, 8'd64, 8'd255};
  logic [1:0]  exp3 [4]  = '{2'd2, 2'd0, 2'd2, 2'd0};
  logic [7:0]  sexp3[4]  = '{8'd248, 8'd8, 8'd248, 8'd8};
  logic [2:0]  rexp3[4]  = '{3'b001, 3'b100, 3'b001, 3'b100};

  initial begin
    rst_n  = 1'b0;
    valid4 = 4'hF;
    ordy4  = 1'b1;
    sum4   = {16'h0600, 16'hFF00, 16'h0100, 16'h0000};
    valid3 = 3'b000;
    ordy3  = 1'b0;
    sum3   = {16'h0400, 16'h0000, 16'hFC00};

    // Reset held across an edge
    #3;
    chk("rst_valid", 32'(ov4), 32'd0);
    chk("rst_id",    32'(id4), 32'd0);
    chk("rst_s",     32'(s4),  32'd0);
    chk("rst_ready", 32'(ready4), 32'd0);
    step();
    chk("rst_ready_edge", 32'(ready4), 32'd0);
    chk("rst_valid_edge", 32'(ov4), 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("rel_ready", 32'(ready4), 32'b0001);

    // Fairness: all valid, drain every cycle
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_valid", 32'(ov4), 32'd1);
      chk("fair_id",    32'(id4), 32'(k % 4));
      chk("fair_s",     32'(s4),  32'(fexp[k % 4]));
      chk("fair_ready", 32'(ready4), 32'(4'(1) << ((k + 1) % 4)));
    end

    // Backpressure: result must freeze, no acceptance
    ordy4 = 1'b0;
    #1 chk("bp_ready0", 32'(ready4), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", 32'(ov4), 32'd1);
      chk("bp_id",    32'(id4), 32'd3);
      chk("bp_s",     32'(s4),  32'd255);
      chk("bp_ready", 32'(ready4), 32'd0);
    end
    ordy4 = 1'b1;
    #1 chk("bp_release_ready", 32'(ready4), 32'b0001);
    step();
    chk("bp_next_id", 32'(id4), 32'd0);
    chk("bp_next_s",  32'(s4),  32'd128);

    // Transfer function through requester 0 only
    valid4 = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      sum4[15:0] = vin[k];
      step();
      chk("val_s",     32'(s4),  32'(vexp[k]));
      chk("val_id",    32'(id4), 32'd0);
      chk("val_valid", 32'(ov4), 32'd1);
    end

    // Drain to EMPTY: id/s hold
    valid4 = 4'b0000;
    step();
    chk("idle_valid", 32'(ov4), 32'd0);
    chk("idle_id",    32'(id4), 32'd0);
    chk("idle_s",     32'(s4),  32'd255);

    // EMPTY accepts even with out_ready low
    ordy4 = 1'b0;
    valid4 = 4'b0010;
    sum4[31:16] = 16'h0100;
    #1 chk("empty_ready", 32'(ready4), 32'b0010);
    step();
    chk("empty_fill_valid", 32'(ov4), 32'd1);
    chk("empty_fill_id",    32'(id4), 32'd1);
    chk("empty_fill_s",     32'(s4),  32'd192);

    // Async reset mid-burst
    ordy4 = 1'b1;
    valid4 = 4'hF;
    step();
    chk("burst_id", 32'(id4), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov4), 32'd0);
    chk("arst_id",    32'(id4), 32'd0);
    chk("arst_s",     32'(s4),  32'd0);
    chk("arst_ready", 32'(ready4), 32'd0);
    #3 rst_n = 1'b1;
    #1 chk("arst_rr0", 32'(ready4), 32'b0001);
    valid4 = 4'b0000;
    step();
    chk("arst_nostale", 32'(ov4), 32'd0);
    valid4 = 4'b0100;
    #1 chk("arst_ready2", 32'(ready4), 32'b0100);
    step();
    chk("arst_new_id", 32'(id4), 32'd2);
    chk("arst_new_s",  32'(s4),  32'd64);
    valid4 = 4'b0000;

    // NUM_REQ=3 skip and wrap
    ordy3 = 1'b1;
    valid3 = 3'b001;
    #1 chk("w3_ready_first", 32'(ready3), 32'b001);
    step();
    chk("w3_first_id", 32'(id3), 32'd0);
    chk("w3_first_s",  32'(s3),  32'd8);
    valid3 = 3'b101;
    #1 chk("w3_ready_pre", 32'(ready3), 32'b100);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("w3_valid", 32'(ov3), 32'd1);
      chk("w3_id",    32'(id3), 32'(exp3[k]));
      chk("w3_s",     32'(s3),  32'(sexp3[k]));
      chk("w3_ready", 32'(ready3), 32'(rexp3[k]));
    end
    valid3 = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
